pipe_out_source: RTL and testbench
==================================

PIPE_OUT_SOURCE -- requirements
Module: pipe_out_source

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 10, buffer address bits (depth = 2^MEM_ADDR_WIDTH words), legal range 2..15.
REQ-002 SHALL have ti_clk  input  1  sole clock; every flop is clocked on its rising edge.
REQ-003 SHALL have ti_rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have flush  input  1  synchronous buffer clear, active-high.
REQ-005 SHALL have s_valid  input  1  user word is valid.
REQ-006 SHALL have s_data  input  16  user word.
REQ-007 SHALL have s_ready  output  1  the buffer can accept a word.
REQ-008 SHALL have ep_read  input  1  host pipe-out read strobe, one cycle ahead of data.
REQ-009 SHALL have ep_datain  output  16  word presented to the host pipe-out endpoint.
REQ-010 SHALL have ti_out_available  output  16  word count for a host wire-out.
REQ-011 SHALL have underflow  output  1  sticky flag: host read an empty buffer.
REQ-012 SHALL have overflow_drop  output  1  sticky flag: s_valid was held while full.

Function
REQ-013 SHALL accept a word (push) at a rising edge when s_valid=1 and s_ready=1; s_ready = not full, driven from registered state only.
REQ-014 SHALL pop at a rising edge when ep_read=1 and the buffer is not empty.
REQ-015 SHALL register ep_datain: after a pop at edge N, the popped word appears on ep_datain from edge N+1 and holds until the next pop or empty read.
REQ-016 SHALL keep words in strict FIFO order, with read and write pointers of MEM_ADDR_WIDTH+1 bits that wrap modulo 2*depth.
REQ-017 SHALL define full as equal addresses with differing MSBs, and empty as equal pointers.
REQ-018 SHALL keep a count of MEM_ADDR_WIDTH+1 bits: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-019 SHALL allow a simultaneous push and pop when full; s_ready stays 0 that cycle because it is registered state, so only the pop occurs.
REQ-020 SHALL allow a simultaneous push and pop when empty; the pop fails (empty read), the push succeeds, and the count becomes 1.
REQ-021 SHALL handle an empty read (ep_read=1 while empty) by driving ep_datain to 16'h0000 from edge N+1, setting underflow, and leaving the pointers unchanged.
REQ-022 SHALL set overflow_drop when s_valid=1 and full at an edge; no word is written.
REQ-023 SHALL drive ti_out_available as the count zero-extended to 16 bits, registered, lagging the count by one cycle.
REQ-024 SHALL implement flush=1 by zeroing the pointers, count, ep_datain, underflow and overflow_drop at the next edge; any push or pop that cycle is ignored.
REQ-025 SHALL use a single-port-write, registered-read buffer that is inferable as block RAM; buffer contents are not reset.

Reset
REQ-026 SHALL, when ti_rst_n=0 at an edge, set pointers=0, count=0, ep_datain=16'h0000, ti_out_available=16'h0000, underflow=0, overflow_drop=0, and s_ready=1 from the next edge.
REQ-027 SHALL let reset take priority over flush, push and pop; a reset during a transfer discards all buffered words.
REQ-028 SHALL NOT assert s_ready while ti_rst_n=0.

Verification
REQ-029 SHALL cover: push 0x1111, 0x2222, 0x3333, then three ep_read pulses -> ep_datain reads 0x1111, 0x2222, 0x3333 one cycle after each strobe; ti_out_available goes 3 -> 0.
REQ-030 SHALL cover, with MEM_ADDR_WIDTH=2: push 5 words with s_valid held -> s_ready=0 after the 4th, overflow_drop=1, ti_out_available=4, and the 5th word is never read.
REQ-031 SHALL cover: ep_read on an empty buffer -> ep_datain=0x0000, underflow=1, count stays 0; a later push then read returns the pushed word.
REQ-032 SHALL cover continuous push and pop for 3*depth words across pointer wrap -> an unbroken incrementing sequence and a constant count.
REQ-033 SHALL cover: ti_rst_n=0 for one cycle with 3 words buffered -> all outputs equal their reset values, and a following read yields 0x0000 with underflow=1.
REQ-034 SHALL cover: flush asserted in the same cycle as a push and a pop -> count=0, ep_datain=0x0000, flags cleared.

Source files
------------

// File: rtl/pipe_out_source.sv
// Host pipe-out source: buffers 16-bit user words in a block-RAM FIFO and
// presents them to the host endpoint one registered cycle after each read strobe.
module pipe_out_source #(
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic        ti_clk,
  input  logic        ti_rst_n,
  input  logic        flush,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  output logic        s_ready,
  input  logic        ep_read,
  output logic [15:0] ep_datain,
  output logic [15:0] ti_out_available,
  output logic        underflow,
  output logic        overflow_drop
);

  localparam int AW     = MEM_ADDR_WIDTH;
  localparam int DEPTH  = 1 << AW;
  localparam int DATA_W = 16;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign s_ready = ti_rst_n && !full;
  assign push    = s_valid && s_ready && !flush;
  assign pop     = ep_read && !empty && !flush && ti_rst_n;

  // Buffer write port; contents are never cleared so the array maps onto block RAM.
  always_ff @(posedge ti_clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= s_data;
    end
  end

  // Registered read port with synchronous clear, doubling as the endpoint data register.
  always_ff @(posedge ti_clk) begin
    if (!ti_rst_n || flush) begin
      ep_datain <= '0;
    end else if (pop) begin
      ep_datain <= mem[rd_ptr[AW-1:0]];
    end else if (ep_read) begin
      ep_datain <= '0;
    end
  end

  always_ff @(posedge ti_clk) begin
    if (!ti_rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ti_clk) begin
    if (!ti_rst_n || flush) begin
      underflow     <= 1'b0;
      overflow_drop <= 1'b0;
    end else begin
      if (ep_read && empty)  underflow     <= 1'b1;
      if (s_valid && full)   overflow_drop <= 1'b1;
    end
  end

  // Host wire-out copy of the count; deliberately one cycle behind.
  always_ff @(posedge ti_clk) begin
    if (!ti_rst_n) begin
      ti_out_available <= '0;
    end else begin
      ti_out_available <= 16'(count);
    end
  end

endmodule

// File: tb/tb_pipe_out_source.sv
// Directed self-checking bench for pipe_out_source with a 4-word buffer.
module tb_pipe_out_source;

  localparam int AW = 2;

  logic        ti_clk = 1'b0;
  logic        ti_rst_n;
  logic        flush;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        ep_read;
  logic [15:0] ep_datain;
  logic [15:0] ti_out_available;
  logic        underflow;
  logic        overflow_drop;

  int n_pass  = 0;
  int n_total = 0;

  pipe_out_source #(.MEM_ADDR_WIDTH(AW)) dut (
    .ti_clk           (ti_clk),
    .ti_rst_n         (ti_rst_n),
    .flush            (flush),
    .s_valid          (s_valid),
    .s_data           (s_data),
    .s_ready          (s_ready),
    .ep_read          (ep_read),
    .ep_datain        (ep_datain),
    .ti_out_available (ti_out_available),
    .underflow        (underflow),
    .overflow_drop    (overflow_drop)
  );

  always #5 ti_clk = ~ti_clk;

  // Advance past the next rising edge; inputs are changed and outputs sampled 1ns later.
  task automatic step();
    @(posedge ti_clk);
    #1;
  endtask

  task automatic test_reset();
    ti_rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; ep_read = 1'b0;
    step(); step();
    n_total++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready: got %b expected 0", s_ready); else n_pass++;
    n_total++; if (ep_datain !== 16'h0000) $display("FAIL rst_ep_datain: got %h expected 0000", ep_datain); else n_pass++;
    n_total++; if (ti_out_available !== 16'h0000) $display("FAIL rst_avail: got %h expected 0000", ti_out_available); else n_pass++;
    n_total++; if ({underflow, overflow_drop} !== 2'b00) $display("FAIL rst_flags: got %b expected 00", {underflow, overflow_drop}); else n_pass++;
    ti_rst_n = 1'b1;
    #1;
    n_total++; if (s_ready !== 1'b1) $display("FAIL rst_release_s_ready: got %b expected 1", s_ready); else n_pass++;
    step();
  endtask

  task automatic test_fifo_order();
    logic [15:0] exp_words [3] = '{16'h1111, 16'h2222, 16'h3333};
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = exp_words[i];
      step();
    end
    s_valid = 1'b0;
    step();
    n_total++; if (ti_out_available !== 16'd3) $display("FAIL order_avail3: got %0d expected 3", ti_out_available); else n_pass++;
    ep_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++; if (ep_datain !== exp_words[i]) $display("FAIL order_word%0d: got %h expected %h", i, ep_datain, exp_words[i]); else n_pass++;
    end
    ep_read = 1'b0;
    step();
    n_total++; if (ti_out_available !== 16'd0) $display("FAIL order_avail0: got %0d expected 0", ti_out_available); else n_pass++;
    n_total++; if (ep_datain !== 16'h3333) $display("FAIL order_hold: got %h expected 3333", ep_datain); else n_pass++;
    n_total++; if (underflow !== 1'b0) $display("FAIL order_underflow: got %b expected 0", underflow); else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 16'hA0A0 + 16'(i);
      step();
    end
    n_total++; if (s_ready !== 1'b0) $display("FAIL ovf_s_ready: got %b expected 0", s_ready); else n_pass++;
    s_data = 16'hA0A4;
    step();
    n_total++; if (overflow_drop !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", overflow_drop); else n_pass++;
    s_valid = 1'b0;
    step();
    n_total++; if (ti_out_available !== 16'd4) $display("FAIL ovf_avail: got %0d expected 4", ti_out_available); else n_pass++;
    ep_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_total++; if (ep_datain !== 16'hA0A0 + 16'(i)) $display("FAIL ovf_word%0d: got %h expected %h", i, ep_datain, 16'hA0A0 + 16'(i)); else n_pass++;
    end
    step();
    ep_read = 1'b0;
    n_total++; if (ep_datain !== 16'h0000) $display("FAIL ovf_fifth: got %h expected 0000", ep_datain); else n_pass++;
    n_total++; if (underflow !== 1'b1) $display("FAIL ovf_underflow: got %b expected 1", underflow); else n_pass++;
  endtask

  task automatic test_flush();
    s_valid = 1'b1; s_data = 16'hB1B1; step();
    s_data = 16'hB2B2; step();
    flush = 1'b1; s_data = 16'hB3B3; ep_read = 1'b1;
    step();
    flush = 1'b0; s_valid = 1'b0; ep_read = 1'b0;
    n_total++; if (ep_datain !== 16'h0000) $display("FAIL flush_ep_datain: got %h expected 0000", ep_datain); else n_pass++;
    n_total++; if ({underflow, overflow_drop} !== 2'b00) $display("FAIL flush_flags: got %b expected 00", {underflow, overflow_drop}); else n_pass++;
    step();
    n_total++; if (ti_out_available !== 16'd0) $display("FAIL flush_avail: got %0d expected 0", ti_out_available); else n_pass++;
    n_total++; if (s_ready !== 1'b1) $display("FAIL flush_s_ready: got %b expected 1", s_ready); else n_pass++;
  endtask

  task automatic test_empty_read();
    ep_read = 1'b1; step(); ep_read = 1'b0;
    n_total++; if (underflow !== 1'b1) $display("FAIL empty_underflow: got %b expected 1", underflow); else n_pass++;
    step();
    n_total++; if (ti_out_available !== 16'd0) $display("FAIL empty_avail: got %0d expected 0", ti_out_available); else n_pass++;
    s_valid = 1'b1; s_data = 16'h5A5A; step(); s_valid = 1'b0;
    ep_read = 1'b1; step(); ep_read = 1'b0;
    n_total++; if (ep_datain !== 16'h5A5A) $display("FAIL empty_then_word: got %h expected 5a5a", ep_datain); else n_pass++;
    // Push and read together on an empty buffer: read misses, push lands.
    s_valid = 1'b1; s_data = 16'h7777; ep_read = 1'b1; step();
    s_valid = 1'b0; ep_read = 1'b0;
    n_total++; if (ep_datain !== 16'h0000) $display("FAIL simul_empty_data: got %h expected 0000", ep_datain); else n_pass++;
    step();
    n_total++; if (ti_out_available !== 16'd1) $display("FAIL simul_empty_avail: got %0d expected 1", ti_out_available); else n_pass++;
    ep_read = 1'b1; step(); ep_read = 1'b0;
    n_total++; if (ep_datain !== 16'h7777) $display("FAIL simul_empty_word: got %h expected 7777", ep_datain); else n_pass++;
  endtask

  task automatic test_wrap();
    s_valid = 1'b1; s_data = 16'h0100; step();
    s_data = 16'h0101; step();
    ep_read = 1'b1;
    for (int i = 0; i < 12; i++) begin
      s_data = 16'h0102 + 16'(i);
      step();
      n_total++; if (ep_datain !== 16'h0100 + 16'(i)) $display("FAIL wrap_word%0d: got %h expected %h", i, ep_datain, 16'h0100 + 16'(i)); else n_pass++;
      n_total++; if (ti_out_available !== 16'd2) $display("FAIL wrap_avail%0d: got %0d expected 2", i, ti_out_available); else n_pass++;
    end
    s_valid = 1'b0;
    for (int i = 12; i < 14; i++) begin
      step();
      n_total++; if (ep_datain !== 16'h0100 + 16'(i)) $display("FAIL wrap_drain%0d: got %h expected %h", i, ep_datain, 16'h0100 + 16'(i)); else n_pass++;
    end
    ep_read = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 16'hC0C0 + 16'(i); step();
    end
    s_valid = 1'b0;
    ep_read = 1'b1; step(); ep_read = 1'b0;
    n_total++; if (ep_datain !== 16'hC0C0) $display("FAIL mid_pre_word: got %h expected c0c0", ep_datain); else n_pass++;
    ti_rst_n = 1'b0; step();
    n_total++; if (s_ready !== 1'b0) $display("FAIL mid_s_ready_low: got %b expected 0", s_ready); else n_pass++;
    n_total++; if (ep_datain !== 16'h0000) $display("FAIL mid_ep_datain: got %h expected 0000", ep_datain); else n_pass++;
    n_total++; if (ti_out_available !== 16'h0000) $display("FAIL mid_avail: got %h expected 0000", ti_out_available); else n_pass++;
    n_total++; if ({underflow, overflow_drop} !== 2'b00) $display("FAIL mid_flags: got %b expected 00", {underflow, overflow_drop}); else n_pass++;
    ti_rst_n = 1'b1; #1;
    n_total++; if (s_ready !== 1'b1) $display("FAIL mid_s_ready_high: got %b expected 1", s_ready); else n_pass++;
    ep_read = 1'b1; step(); ep_read = 1'b0;
    n_total++; if (ep_datain !== 16'h0000) $display("FAIL mid_read_data: got %h expected 0000", ep_datain); else n_pass++;
    n_total++; if (underflow !== 1'b1) $display("FAIL mid_read_underflow: got %b expected 1", underflow); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_overflow();
    test_flush();
    test_empty_read();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
